// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: MEM wait-state encodings and register-address helpers.
// Latency: n/a (types and pure functions only); backpressure: n/a.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_LEN = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic reg_match(
        input logic [REG_ADDR_LEN-1:0] src,
        input logic [REG_ADDR_LEN-1:0] dest,
        input logic                    en
    );
        return en && (src != '0) && (src == dest);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard.sv
// RAW / load-use hazard compare between the ID sources and the EXE/MEM destinations.
// Latency: 0 cycles (combinational); backpressure: none, the result feeds the stall priority mux.
module pipeline_ctrl_hazard
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_ADDR_LEN-1:0] i_src1,
    input  logic [REG_ADDR_LEN-1:0] i_src2,
    input  logic                    i_two_src,
    input  logic [REG_ADDR_LEN-1:0] i_exe_dest,
    input  logic                    i_exe_wb_en,
    input  logic                    i_exe_mem_read,
    input  logic [REG_ADDR_LEN-1:0] i_mem_dest,
    input  logic                    i_mem_wb_en,
    input  logic                    i_forward_en,
    output logic                    o_hazard
);

    logic w_load_use;
    logic w_raw;

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign w_load_use = reg_match(i_src1, i_exe_dest, i_exe_mem_read)
                      | (i_two_src & reg_match(i_src2, i_exe_dest, i_exe_mem_read));

    assign w_raw = reg_match(i_src1, i_exe_dest, i_exe_wb_en)
                 | reg_match(i_src1, i_mem_dest, i_mem_wb_en)
                 | (i_two_src & (reg_match(i_src2, i_exe_dest, i_exe_wb_en)
                               | reg_match(i_src2, i_mem_dest, i_mem_wb_en)));

    assign o_hazard = i_forward_en ? w_load_use : w_raw;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: MEM wait-state FSM, hazard/branch priority mux and saturating perf counters.
// Latency: controls are combinational from inputs and FSM state; backpressure: holds pipeline while MEM access is outstanding.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int SRAM_WAIT = 5,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_forward_en,
    input  logic [REG_ADDR_LEN-1:0] i_id_src1,
    input  logic [REG_ADDR_LEN-1:0] i_id_src2,
    input  logic                    i_id_two_src,
    input  logic [REG_ADDR_LEN-1:0] i_exe_dest,
    input  logic                    i_exe_wb_en,
    input  logic                    i_exe_mem_read,
    input  logic [REG_ADDR_LEN-1:0] i_mem_dest,
    input  logic                    i_mem_wb_en,
    input  logic                    i_mem_req,
    input  logic                    i_sram_ready,
    input  logic                    i_br_taken,
    output logic                    o_pc_freeze,
    output logic                    o_ifid_freeze,
    output logic                    o_ifid_flush,
    output logic                    o_idex_bubble,
    output logic                    o_pipe_hold,
    output logic                    o_mem_timeout,
    output logic [CNT_W-1:0]        o_stall_cnt,
    output logic [CNT_W-1:0]        o_flush_cnt
);

    localparam int WCNT_W = $clog2(SRAM_WAIT + 1);

    mem_state_e        r_state;
    logic [WCNT_W-1:0] r_wcnt;
    logic              r_mem_timeout;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_hazard;
    logic w_mem_stall;
    logic w_pc_freeze;
    logic w_ifid_freeze;
    logic w_ifid_flush;
    logic w_idex_bubble;
    logic w_pipe_hold;

    pipeline_ctrl_hazard u_hazard (
        .i_src1         (i_id_src1),
        .i_src2         (i_id_src2),
        .i_two_src      (i_id_two_src),
        .i_exe_dest     (i_exe_dest),
        .i_exe_wb_en    (i_exe_wb_en),
        .i_exe_mem_read (i_exe_mem_read),
        .i_mem_dest     (i_mem_dest),
        .i_mem_wb_en    (i_mem_wb_en),
        .i_forward_en   (i_forward_en),
        .o_hazard       (w_hazard)
    );

    // Hold starts in the request cycle itself so the MEM stage never advances under a fresh access.
    assign w_mem_stall = ((r_state == ST_IDLE) && i_mem_req) || (r_state == ST_WAIT);

    always_comb begin
        w_pc_freeze   = 1'b0;
        w_ifid_freeze = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_pipe_hold   = 1'b0;
        if (rst_n) begin
            if (w_mem_stall) begin
                w_pc_freeze   = 1'b1;
                w_ifid_freeze = 1'b1;
                w_pipe_hold   = 1'b1;
            end else if (i_br_taken) begin
                w_ifid_flush  = 1'b1;
                w_idex_bubble = 1'b1;
            end else if (w_hazard) begin
                w_pc_freeze   = 1'b1;
                w_ifid_freeze = 1'b1;
                w_idex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_wcnt        <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_mem_req) begin
                        r_state <= ST_WAIT;
                        r_wcnt  <= WCNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    r_wcnt <= r_wcnt + WCNT_W'(1);
                    if (i_sram_ready) begin
                        r_state <= ST_DONE;
                    end else if (r_wcnt == WCNT_W'(SRAM_WAIT - 1)) begin
                        r_state       <= ST_DONE;
                        r_mem_timeout <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_wcnt  <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_wcnt  <= '0;
                end
            endcase

            if (w_pc_freeze && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_ifid_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign o_pc_freeze   = w_pc_freeze;
    assign o_ifid_freeze = w_ifid_freeze;
    assign o_ifid_flush  = w_ifid_flush;
    assign o_idex_bubble = w_idex_bubble;
    assign o_pipe_hold   = w_pipe_hold;
    assign o_mem_timeout = r_mem_timeout;
    assign o_stall_cnt   = r_stall_cnt;
    assign o_flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then randomized traffic against a cycle-level reference model.
// Latency/backpressure: inputs change on the falling edge, outputs are compared just after.
module tb_pipeline_ctrl;

    localparam int SRAM_WAIT = 5;
    localparam int CNT_W     = 8;
    localparam int CMAX      = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       forward_en, id_two_src, exe_wb_en, exe_mem_read, mem_wb_en;
    logic       mem_req, sram_ready, br_taken;
    logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       pc_freeze, ifid_freeze, ifid_flush, idex_bubble, pipe_hold, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: cycles spent waiting on the current access (0 = none),
    // a one-cycle release flag, sticky timeout, and plain integer counters.
    int m_wait;
    bit m_rel;
    bit m_tmo;
    int m_stall;
    int m_flush;

    always #5 clk = ~clk;

    pipeline_ctrl #(.SRAM_WAIT(SRAM_WAIT), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_forward_en   (forward_en),
        .i_id_src1      (id_src1),
        .i_id_src2      (id_src2),
        .i_id_two_src   (id_two_src),
        .i_exe_dest     (exe_dest),
        .i_exe_wb_en    (exe_wb_en),
        .i_exe_mem_read (exe_mem_read),
        .i_mem_dest     (mem_dest),
        .i_mem_wb_en    (mem_wb_en),
        .i_mem_req      (mem_req),
        .i_sram_ready   (sram_ready),
        .i_br_taken     (br_taken),
        .o_pc_freeze    (pc_freeze),
        .o_ifid_freeze  (ifid_freeze),
        .o_ifid_flush   (ifid_flush),
        .o_idex_bubble  (idex_bubble),
        .o_pipe_hold    (pipe_hold),
        .o_mem_timeout  (mem_timeout),
        .o_stall_cnt    (stall_cnt),
        .o_flush_cnt    (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_hazard();
        int srcs[$];
        bit hz = 0;
        srcs.push_back(int'(id_src1));
        if (id_two_src) srcs.push_back(int'(id_src2));
        foreach (srcs[k]) begin
            if (srcs[k] != 0) begin
                if (forward_en) begin
                    if (exe_mem_read && srcs[k] == int'(exe_dest)) hz = 1;
                end else begin
                    if (exe_wb_en && srcs[k] == int'(exe_dest)) hz = 1;
                    if (mem_wb_en && srcs[k] == int'(mem_dest)) hz = 1;
                end
            end
        end
        return hz;
    endfunction

    task automatic model_reset();
        m_wait  = 0;
        m_rel   = 0;
        m_tmo   = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Inputs were set on the falling edge; compare, advance the model, wait for the next falling edge.
    task automatic step();
        bit         hold;
        logic [4:0] e;
        #1;
        if (!rst_n) model_reset();
        hold = rst_n && ((m_wait == 0 && !m_rel && mem_req) || m_wait > 0);
        // {pc_freeze, ifid_freeze, ifid_flush, idex_bubble, pipe_hold}
        if (!rst_n)          e = 5'b00000;
        else if (hold)       e = 5'b11001;
        else if (br_taken)   e = 5'b00110;
        else if (ref_hazard()) e = 5'b11010;
        else                 e = 5'b00000;
        chk("ctl", {pc_freeze, ifid_freeze, ifid_flush, idex_bubble, pipe_hold}, e);
        chk("mem_timeout", 32'(mem_timeout), 32'(m_tmo));
        chk("stall_cnt", 32'(stall_cnt), m_stall);
        chk("flush_cnt", 32'(flush_cnt), m_flush);
        if (rst_n) begin
            if (e[4] && m_stall < CMAX) m_stall++;
            if (e[2] && m_flush < CMAX) m_flush++;
            if (m_rel) begin
                m_rel = 0;
            end else if (m_wait == 0) begin
                if (mem_req) m_wait = 1;
            end else if (sram_ready || m_wait == SRAM_WAIT - 1) begin
                if (!sram_ready) m_tmo = 1;
                m_wait = 0;
                m_rel  = 1;
            end else begin
                m_wait++;
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        forward_en = 0; id_two_src = 0; exe_wb_en = 0; exe_mem_read = 0; mem_wb_en = 0;
        mem_req = 0; sram_ready = 0; br_taken = 0;
        id_src1 = 0; id_src2 = 0; exe_dest = 0; mem_dest = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        clear_inputs();
        rst_n = 0;
        @(negedge clk);

        // Reset held across several edges, then released with no requests.
        repeat (3) step();
        chk("rst_outs", {pc_freeze, ifid_freeze, ifid_flush, idex_bubble, pipe_hold, mem_timeout}, 6'b0);
        rst_n = 1;
        repeat (2) step();

        // Load-use with forwarding: one stall cycle.
        forward_en = 1; exe_mem_read = 1; exe_dest = 5; id_src1 = 5;
        #1 chk("t2_stall", {pc_freeze, ifid_freeze, idex_bubble}, 3'b111);
        step();
        clear_inputs();
        #1 chk("t2_release", 32'(pc_freeze), 0);
        chk("t2_stall_cnt", 32'(stall_cnt), 1);
        step();

        // RAW through src2 without forwarding, then the two non-hazard variants.
        mem_wb_en = 1; mem_dest = 3; id_two_src = 1; id_src2 = 3;
        #1 chk("t3_hz", 32'(idex_bubble), 1);
        step();
        id_two_src = 0;
        #1 chk("t3_one_src", 32'(idex_bubble), 0);
        step();
        id_two_src = 1; mem_dest = 0; id_src2 = 0;
        #1 chk("t3_r0", 32'(idex_bubble), 0);
        step();
        clear_inputs();

        // MEM access completing on the third WAIT cycle.
        mem_req = 1;
        for (int i = 0; i < 4; i++) begin
            sram_ready = (i == 3);
            #1 chk("t4_hold", 32'(pipe_hold), 1);
            step();
        end
        mem_req = 0; sram_ready = 0;
        #1 chk("t4_done", 32'(pipe_hold), 0);
        step();
        step();
        chk("t4_tmo", 32'(mem_timeout), 0);

        // MEM access that never sees sram_ready.
        mem_req = 1;
        step();
        mem_req = 0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t5_hold", 32'(pipe_hold), 1);
            step();
        end
        #1 chk("t5_release", 32'(pipe_hold), 0);
        chk("t5_tmo", 32'(mem_timeout), 1);
        repeat (3) step();
        chk("t5_tmo_sticky", 32'(mem_timeout), 1);

        // Branch wins over a simultaneous hazard.
        br_taken = 1; exe_wb_en = 1; exe_dest = 7; id_src1 = 7;
        #1 chk("t6_br_hz", {ifid_flush, idex_bubble, pc_freeze}, 3'b110);
        step();

        // Branch during WAIT is deferred until the hold drops.
        do_reset();
        mem_req = 1; br_taken = 1;
        step();
        mem_req = 0;
        step();
        sram_ready = 1;
        #1 chk("t6_no_flush", 32'(ifid_flush), 0);
        step();
        sram_ready = 0;
        #1 chk("t6_flush_done", 32'(ifid_flush), 1);
        step();
        br_taken = 0;
        #1 chk("t6_flush_cnt", 32'(flush_cnt), 1);
        step();

        // Stall counter saturates rather than wrapping.
        do_reset();
        forward_en = 1; exe_mem_read = 1; exe_dest = 9; id_src1 = 9;
        repeat (CMAX + 20) step();
        chk("sat_stall_cnt", 32'(stall_cnt), CMAX);
        clear_inputs();
        step();

        // Randomized traffic with small register ranges to provoke matches, plus occasional async resets.
        for (int n = 0; n < 3000; n++) begin
            rst_n        = ($urandom_range(0, 149) != 0);
            forward_en   = $urandom_range(0, 1) != 0;
            id_two_src   = $urandom_range(0, 1) != 0;
            exe_wb_en    = $urandom_range(0, 1) != 0;
            exe_mem_read = $urandom_range(0, 2) == 0;
            mem_wb_en    = $urandom_range(0, 1) != 0;
            mem_req      = $urandom_range(0, 3) == 0;
            sram_ready   = $urandom_range(0, 2) == 0;
            br_taken     = $urandom_range(0, 7) == 0;
            id_src1      = 5'($urandom_range(0, 3));
            id_src2      = 5'($urandom_range(0, 3));
            exe_dest     = 5'($urandom_range(0, 3));
            mem_dest     = 5'($urandom_range(0, 3));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
